cpu_bus_copier: RTL
===================

Name: cpu_bus_copier

Overview:
- Bus initiator (DMA-style word copier) for the CPU memory-bus protocol: request/rw/address/wdata out, rdata/ready/valid in.
- Drives bus responders such as block RAMs and peripherals.
- On command, copies N words from a source address to a destination address with alternating read/write transactions.
- Reports busy, done and error status to the controlling CPU register block.

Parameters:
ADDRESS_WIDTH, 32, bus address width in bits
DATA_WIDTH, 32, bus data width in bits
COUNT_WIDTH, 16, width of word-count field
STRIDE, 4, byte increment applied to src/dst after each word

Ports:
i_clock  input  1  clock, all logic on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_start  input  1  command strobe, sampled only in IDLE
i_src_address  input  ADDRESS_WIDTH  source byte address, latched on accepted start
i_dst_address  input  ADDRESS_WIDTH  destination byte address, latched on accepted start
i_count  input  COUNT_WIDTH  number of words, latched on accepted start
o_busy  output  1  high from cycle after accepted start until DONE
o_done  output  1  one-cycle completion pulse, success or error
o_error  output  1  sticky bus error flag, cleared on next accepted start
o_bus_request  output  1  transaction request
o_bus_rw  output  1  0 = read, 1 = write
o_bus_address  output  ADDRESS_WIDTH  transaction byte address
o_bus_wdata  output  DATA_WIDTH  write data
i_bus_rdata  input  DATA_WIDTH  read data, valid when i_bus_ready=1 for a read
i_bus_ready  input  1  transaction complete
i_bus_valid  input  1  0 with ready = address not decoded (error)

Behaviour:
- Clock and reset: one clock, i_clock. Reset i_reset_n is asynchronous, active-low.
- Reset state:
  - State = IDLE.
  - o_busy, o_done, o_error, o_bus_request, o_bus_rw = 0.
  - o_bus_address, o_bus_wdata = 0.
  - Internal src, dst, remaining and buffer registers = 0.
- Outputs are decoded from registered state only. There is no combinational path from any input to any output.
- States: IDLE, READ, READ_GAP, WRITE, WRITE_GAP, DONE.
- IDLE:
  - i_start=1 and i_count!=0: latch src, dst and remaining=i_count; clear o_error; go to READ.
  - i_start=1 and i_count=0: clear o_error; go directly to DONE. No bus activity.
- READ:
  - Outputs: request=1, rw=0, address=src.
  - Hold all bus outputs stable until i_bus_ready=1 is sampled. Wait states are unbounded.
  - On ready with valid=1: buffer<=i_bus_rdata; go to READ_GAP.
  - On ready with valid=0: o_error<=1; go to DONE.
- READ_GAP:
  - request=0 for exactly one cycle; i_bus_ready is ignored.
  - Required because the responder's ready is registered from request and stays high one cycle after request drops.
  - Next state: WRITE.
- WRITE:
  - Outputs: request=1, rw=1, address=dst, wdata=buffer.
  - On ready with valid=1: src+=STRIDE, dst+=STRIDE, remaining-=1; go to WRITE_GAP.
  - On ready with valid=0: o_error<=1; go to DONE.
- WRITE_GAP:
  - request=0 for one cycle; ready is ignored.
  - remaining==0: go to DONE; otherwise go to READ.
- DONE: o_done=1, o_busy=0 for one cycle; next state IDLE.
- o_busy=1 in READ, READ_GAP, WRITE, WRITE_GAP.
- Address arithmetic: modulo 2^ADDRESS_WIDTH, so wrap past all-ones is silent.
- Throughput: 6 cycles/word with a zero-wait responder (1 request cycle + 1 ready cycle + 1 gap, per transaction).
- Start handling: i_start outside IDLE is ignored; no queuing.
- Reset mid-transfer: immediate return to reset state; request drops asynchronously; partial copy is left in memory.
- Error handling: the erroring word is not written. Words already copied remain. Remaining words are abandoned.
- o_bus_wdata and o_bus_address hold their last value when request=0.

Test Plan:
- 1-word copy against a zero-wait BRAM model: mem[0x10]=0xDEADBEEF; start src=0x10, dst=0x40, count=1 at cycle 0 -> read request in cycles 1-2, write request in cycles 4-5, o_done high in cycle 7; mem[0x40]=0xDEADBEEF.
- 4-word copy: src=0x0, dst=0x100, count=4, pattern 0x11..0x44 -> dst words match; exactly 8 transactions; addresses step by 4; o_busy high for 24 cycles.
- count=0 -> o_done one cycle after start; o_bus_request never asserted; o_error=0.
- Out-of-range destination: responder returns valid=0 on the write to 0x1000 -> o_error=1, o_done pulses, no further requests; next start with a good range clears o_error.
- Responder with 3 wait states and i_start pulsed while busy -> bus outputs stable while waiting; second start ignored; copy completes correctly.
- Reset asserted in WRITE of word 2 of 4 -> request low immediately; all outputs at reset values; after release, a new start runs normally.

Source files
------------

// File: rtl/cpu_bus_copier.sv
// cpu_bus_copier
// Bus initiator that copies a block of words from a source byte address to a
// destination byte address using alternating read and write transactions.
// Every output is a register; nothing combinational reaches the ports.
//
// State table:
//   IDLE      | waiting for a start command
//   READ      | read request held until the responder signals ready
//   READ_GAP  | one cycle with the request low (absorbs the trailing ready)
//   WRITE     | write request held until the responder signals ready
//   WRITE_GAP | one cycle with the request low, then next word or finish
//   DONE      | one-cycle completion pulse
//
// Ports:
//   i_clock, i_reset_n          clock, asynchronous active-low reset
//   i_start                     command strobe, only honoured in IDLE
//   i_src_address/i_dst_address byte addresses latched on an accepted start
//   i_count                     number of words to copy
//   o_busy, o_done, o_error     status towards the CPU register block
//   o_bus_request/rw/address/wdata   bus request side
//   i_bus_rdata/ready/valid          bus response side
module cpu_bus_copier #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int COUNT_WIDTH   = 16,
    parameter int STRIDE        = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH-1:0] i_src_address,
    input  logic [ADDRESS_WIDTH-1:0] i_dst_address,
    input  logic [COUNT_WIDTH-1:0]   i_count,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    output logic                     o_bus_request,
    output logic                     o_bus_rw,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic [DATA_WIDTH-1:0]    o_bus_wdata,
    input  logic [DATA_WIDTH-1:0]    i_bus_rdata,
    input  logic                     i_bus_ready,
    input  logic                     i_bus_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_READ_GAP,
        S_WRITE,
        S_WRITE_GAP,
        S_DONE
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(STRIDE);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] src;
    logic [ADDRESS_WIDTH-1:0] dst;
    logic [COUNT_WIDTH-1:0]   remaining;
    logic [DATA_WIDTH-1:0]    buffer;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= S_IDLE;
            src           <= '0;
            dst           <= '0;
            remaining     <= '0;
            buffer        <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_error <= 1'b0;
                        if (i_count != '0) begin
                            src           <= i_src_address;
                            dst           <= i_dst_address;
                            remaining     <= i_count;
                            o_busy        <= 1'b1;
                            o_bus_request <= 1'b1;
                            o_bus_rw      <= 1'b0;
                            o_bus_address <= i_src_address;
                            state         <= S_READ;
                        end else begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end

                S_READ: begin
                    if (i_bus_ready) begin
                        o_bus_request <= 1'b0;
                        if (i_bus_valid) begin
                            buffer <= i_bus_rdata;
                            state  <= S_READ_GAP;
                        end else begin
                            o_error <= 1'b1;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end

                // The responder's ready is still high here; it is deliberately
                // not looked at.
                S_READ_GAP: begin
                    o_bus_request <= 1'b1;
                    o_bus_rw      <= 1'b1;
                    o_bus_address <= dst;
                    o_bus_wdata   <= buffer;
                    state         <= S_WRITE;
                end

                S_WRITE: begin
                    if (i_bus_ready) begin
                        o_bus_request <= 1'b0;
                        if (i_bus_valid) begin
                            src       <= src + STEP;
                            dst       <= dst + STEP;
                            remaining <= remaining - COUNT_WIDTH'(1);
                            state     <= S_WRITE_GAP;
                        end else begin
                            o_error <= 1'b1;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end

                S_WRITE_GAP: begin
                    if (remaining == '0) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        o_bus_request <= 1'b1;
                        o_bus_rw      <= 1'b0;
                        o_bus_address <= src;
                        state         <= S_READ;
                    end
                end

                S_DONE: begin
                    o_done <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    o_busy        <= 1'b0;
                    o_done        <= 1'b0;
                    o_bus_request <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule
